reg_xfer_seq: RTL and testbench
===============================

REG_XFER_SEQ -- requirements
Module: reg_xfer_seq

Interface
REQ-001 SHALL have parameter SIGNAL_WIDTH, default `REG_WIDTH (8): data width of the register transfer path.
REQ-002 SHALL have parameter SELECTOR_WIDTH, default 4: width of source/destination register selectors.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: number of queued transfer requests.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1: transfer request offered.
REQ-008 SHALL have port req_ready, output, 1: request queue not full.
REQ-009 SHALL have port req_src, input, SELECTOR_WIDTH: source register index.
REQ-010 SHALL have port req_dst, input, SELECTOR_WIDTH: destination index; all-ones means null destination.
REQ-011 SHALL have port req_setflags, input, 1: update N/Z from transferred value.
REQ-012 SHALL have port mux_sel, output, SELECTOR_WIDTH: drives the 16:1 register-select mux.
REQ-013 SHALL have port mux_data, input, SIGNAL_WIDTH: selected register value returned by the mux.
REQ-014 SHALL have ports wr_en (1), wr_sel (SELECTOR_WIDTH), wr_data (SIGNAL_WIDTH), all outputs: register-file write strobe, index and data.
REQ-015 SHALL have ports flag_we, flag_n, flag_z, all 1-bit outputs: status-flag update strobe and values.
REQ-016 SHALL have ports busy and done, both 1-bit outputs: sequencer active; one-cycle completion pulse.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, pushing {src,dst,setflags} into a FIFO_DEPTH-entry FIFO.
REQ-018 SHALL drive req_ready = 0 when the FIFO is full; req_ready SHALL NOT depend combinationally on req_valid.
REQ-019 SHALL implement FSM states IDLE, SELECT, CAPTURE and WRITE.
REQ-020 SHALL transition IDLE->SELECT when the FIFO is non-empty, popping the head entry into working registers.
REQ-021 SHALL transition SELECT->CAPTURE unconditionally, holding mux_sel = working src during SELECT and CAPTURE.
REQ-022 SHALL transition CAPTURE->WRITE and register mux_data into the data latch at the end of CAPTURE.
REQ-023 SHALL, in WRITE, pulse wr_en for exactly one cycle with wr_sel = dst and wr_data = latched value; wr_en SHALL stay 0 when dst is all-ones.
REQ-024 SHALL, in WRITE with setflags = 1, pulse flag_we with flag_n = data MSB and flag_z = (data == 0); otherwise flag_we = 0.
REQ-025 SHALL pulse done in WRITE; from WRITE, go to SELECT if the FIFO is non-empty (back-to-back, 3 cycles per transfer), else to IDLE.
REQ-026 SHALL produce first wr_en 3 cycles after the accepting edge when idle with an empty FIFO.
REQ-027 SHALL, on a simultaneous push and pop with the FIFO full, accept the push; the pop frees the slot in the same cycle.
REQ-028 SHALL treat src == dst as a normal transfer, rewriting the same value.
REQ-029 SHALL drive busy = 1 in every state except IDLE.
REQ-030 SHALL hold mux_sel at 0 in IDLE.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-transfer, immediately force: state IDLE; FIFO empty; req_ready 1; mux_sel 0; wr_en, wr_sel, wr_data 0; flag_we, flag_n, flag_z 0; busy 0; done 0.
REQ-032 SHALL discard any interrupted transfer, with no write after reset release.

Structure
REQ-033 SHALL place FSM state encodings and the null-destination constant in the shared project defines include, alongside `REG_WIDTH.
REQ-034 SHALL implement the request queue as a separate sub-module req_fifo (parameterised width/depth, push/pop, full/empty).

Verification
REQ-035 SHALL verify a single transfer: src=3 (mux_data=8'h80), dst=5, setflags=1 -> wr_en at cycle 3, wr_sel=5, wr_data=8'h80, flag_n=1, flag_z=0, done pulse.
REQ-036 SHALL verify back-to-back transfers: 3 requests, 1 per cycle -> req_ready drops after 2 queued; writes occur at cycles 3, 6 and 9; busy stays high throughout.
REQ-037 SHALL verify the null destination: dst=4'hF, src=2 (8'h00), setflags=1 -> wr_en stays 0, flag_we=1, flag_z=1, done pulses.
REQ-038 SHALL verify a flagless transfer: setflags=0, mux_data=8'h00 -> flag_we stays 0, wr_data=8'h00.
REQ-039 SHALL verify reset mid-operation: rst_n low during CAPTURE with 1 request queued -> all outputs at reset values next sample, no wr_en after release, req_ready=1.
REQ-040 SHALL verify full-FIFO simultaneous push/pop: FIFO full, WRITE->SELECT pop coinciding with req_valid -> request accepted, order preserved.

Source files
------------

// File: rtl/reg_xfer_seq_pkg.sv
// rtl/reg_xfer_seq_pkg.sv - shared defines and types for the register transfer sequencer
`ifndef REG_XFER_SEQ_DEFINES
`define REG_XFER_SEQ_DEFINES
`define REG_WIDTH      8
`define XFER_ST_IDLE   2'd0
`define XFER_ST_SELECT 2'd1
`define XFER_ST_CAPT   2'd2
`define XFER_ST_WRITE  2'd3
`define XFER_NULL_DST  '1
`endif

package reg_xfer_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = `XFER_ST_IDLE,
        ST_SELECT  = `XFER_ST_SELECT,
        ST_CAPTURE = `XFER_ST_CAPT,
        ST_WRITE   = `XFER_ST_WRITE
    } xfer_state_e;

endpackage

// File: rtl/reg_xfer_seq_req_fifo.sv
// rtl/reg_xfer_seq_req_fifo.sv - request queue; a push into a full queue is taken when a pop frees a slot
module req_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/reg_xfer_seq.sv
// rtl/reg_xfer_seq.sv - queued register-to-register transfer sequencer (select, capture, write)
module reg_xfer_seq
    import reg_xfer_seq_pkg::*;
#(
    parameter int SIGNAL_WIDTH   = `REG_WIDTH,
    parameter int SELECTOR_WIDTH = 4,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SELECTOR_WIDTH-1:0] req_src,
    input  logic [SELECTOR_WIDTH-1:0] req_dst,
    input  logic                      req_setflags,
    output logic [SELECTOR_WIDTH-1:0] mux_sel,
    input  logic [SIGNAL_WIDTH-1:0]   mux_data,
    output logic                      wr_en,
    output logic [SELECTOR_WIDTH-1:0] wr_sel,
    output logic [SIGNAL_WIDTH-1:0]   wr_data,
    output logic                      flag_we,
    output logic                      flag_n,
    output logic                      flag_z,
    output logic                      busy,
    output logic                      done
);

    localparam int ENTRY_W = 2 * SELECTOR_WIDTH + 1;
    localparam logic [SELECTOR_WIDTH-1:0] NULL_DST = `XFER_NULL_DST;

    xfer_state_e               state_q, state_d;
    logic [SELECTOR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic                      setflags_q, setflags_d;
    logic [SIGNAL_WIDTH-1:0]   data_q, data_d;

    logic                      fifo_full, fifo_empty, pop;
    logic [ENTRY_W-1:0]        head;
    logic [SELECTOR_WIDTH-1:0] head_src, head_dst;
    logic                      head_setflags;

    // Popping depends only on state and occupancy, so req_ready never sees req_valid.
    assign pop       = !fifo_empty && (state_q == ST_IDLE || state_q == ST_WRITE);
    assign req_ready = !fifo_full || pop;
    assign {head_src, head_dst, head_setflags} = head;

    req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid && req_ready),
        .push_data ({req_src, req_dst, req_setflags}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        setflags_d = setflags_q;
        data_d     = data_q;
        mux_sel    = '0;
        wr_en      = 1'b0;
        wr_sel     = '0;
        wr_data    = '0;
        flag_we    = 1'b0;
        flag_n     = 1'b0;
        flag_z     = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d    = ST_SELECT;
                    src_d      = head_src;
                    dst_d      = head_dst;
                    setflags_d = head_setflags;
                end
            end
            ST_SELECT: begin
                mux_sel = src_q;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                mux_sel = src_q;
                data_d  = mux_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                done    = 1'b1;
                wr_en   = (dst_q != NULL_DST);
                wr_sel  = dst_q;
                wr_data = data_q;
                flag_we = setflags_q;
                flag_n  = setflags_q & data_q[SIGNAL_WIDTH-1];
                flag_z  = setflags_q & (data_q == '0);
                if (pop) begin
                    state_d    = ST_SELECT;
                    src_d      = head_src;
                    dst_d      = head_dst;
                    setflags_d = head_setflags;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            setflags_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            setflags_q <= setflags_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_reg_xfer_seq.sv
// tb/tb_reg_xfer_seq.sv - randomized self-checking bench for reg_xfer_seq against a transfer timeline model
module tb_reg_xfer_seq;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_setflags;
    logic [3:0] req_src, req_dst, mux_sel, wr_sel;
    logic [7:0] mux_data, wr_data;
    logic       wr_en, flag_we, flag_n, flag_z, busy, done;

    logic [7:0] regs [16];
    assign mux_data = regs[mux_sel];

    always #5 clk = ~clk;

    reg_xfer_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .req_setflags (req_setflags),
        .mux_sel      (mux_sel),
        .mux_data     (mux_data),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .flag_we      (flag_we),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [3:0] src;
        logic [3:0] dst;
        logic       sf;
        int         w;
    } xfer_t;

    xfer_t stim [$];
    xfer_t mq [$];
    int    cyc = 0;
    int    last_w = -100;
    int    errors = 0;
    int    checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ready"},   32'(req_ready), 32'd1);
        check_eq({tag, "_mux_sel"}, 32'(mux_sel),   32'd0);
        check_eq({tag, "_wr_en"},   32'(wr_en),     32'd0);
        check_eq({tag, "_wr_sel"},  32'(wr_sel),    32'd0);
        check_eq({tag, "_wr_data"}, 32'(wr_data),   32'd0);
        check_eq({tag, "_flag_we"}, 32'(flag_we),   32'd0);
        check_eq({tag, "_flag_n"},  32'(flag_n),    32'd0);
        check_eq({tag, "_flag_z"},  32'(flag_z),    32'd0);
        check_eq({tag, "_busy"},    32'(busy),      32'd0);
        check_eq({tag, "_done"},    32'(done),      32'd0);
    endtask

    task automatic add_req(input logic [3:0] src, input logic [3:0] dst, input logic sf);
        xfer_t t;
        t.src = src;
        t.dst = dst;
        t.sf  = sf;
        t.w   = 0;
        stim.push_back(t);
    endtask

    // Each accepted request is written three cycles after acceptance, but never
    // sooner than three cycles after the previous write.
    task automatic run_cycle();
        logic       exp_busy, exp_done, exp_wen, exp_fwe, exp_fn, exp_fz, exp_ready, pop_next, accept;
        logic [3:0] exp_mux, exp_wsel;
        logic [7:0] exp_wdat;
        int         occ;
        xfer_t      t;
        @(negedge clk);
        if (stim.size() != 0) begin
            req_valid    = 1'b1;
            req_src      = stim[0].src;
            req_dst      = stim[0].dst;
            req_setflags = stim[0].sf;
        end else begin
            req_valid    = 1'b0;
            req_src      = 4'($urandom);
            req_dst      = 4'($urandom);
            req_setflags = 1'($urandom);
        end
        exp_busy = 0; exp_done = 0; exp_wen = 0; exp_fwe = 0; exp_fn = 0; exp_fz = 0;
        exp_mux = 0; exp_wsel = 0; exp_wdat = 0; occ = 0; pop_next = 0;
        foreach (mq[i]) begin
            if (mq[i].w - 2 > cyc) occ++;
            if (mq[i].w - 2 == cyc + 1) pop_next = 1;
            if (cyc >= mq[i].w - 2 && cyc <= mq[i].w) exp_busy = 1;
            if (cyc == mq[i].w - 2 || cyc == mq[i].w - 1) exp_mux = mq[i].src;
            if (cyc == mq[i].w) begin
                exp_done = 1;
                exp_wdat = regs[mq[i].src];
                exp_wsel = mq[i].dst;
                exp_wen  = (mq[i].dst != 4'hF);
                exp_fwe  = mq[i].sf;
                exp_fn   = mq[i].sf & exp_wdat[7];
                exp_fz   = mq[i].sf & (exp_wdat == 8'h00);
            end
        end
        exp_ready = (occ < DEPTH) || pop_next;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("busy",      32'(busy),      32'(exp_busy));
        check_eq("done",      32'(done),      32'(exp_done));
        check_eq("mux_sel",   32'(mux_sel),   32'(exp_mux));
        check_eq("wr_en",     32'(wr_en),     32'(exp_wen));
        check_eq("flag_we",   32'(flag_we),   32'(exp_fwe));
        check_eq("flag_n",    32'(flag_n),    32'(exp_fn));
        check_eq("flag_z",    32'(flag_z),    32'(exp_fz));
        if (exp_wen) begin
            check_eq("wr_sel",  32'(wr_sel),  32'(exp_wsel));
            check_eq("wr_data", 32'(wr_data), 32'(exp_wdat));
        end
        accept = req_valid && exp_ready;
        while (mq.size() != 0 && mq[0].w <= cyc) void'(mq.pop_front());
        @(posedge clk);
        cyc++;
        if (accept) begin
            t      = stim.pop_front();
            t.w    = (cyc + 3 > last_w + 3) ? cyc + 3 : last_w + 3;
            last_w = t.w;
            mq.push_back(t);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((stim.size() != 0 || mq.size() != 0) && n < 200) begin
            run_cycle();
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", 32'(stim.size() + mq.size()), 32'd0);
        run_cycle();
        run_cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_setflags = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
        #2;
        check_reset("por");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        regs[3] = 8'h80;
        add_req(4'd3, 4'd5, 1'b1);
        drain();

        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
        add_req(4'd1, 4'd6, 1'b1);
        add_req(4'd4, 4'd7, 1'b0);
        add_req(4'd8, 4'd9, 1'b1);
        drain();

        regs[2] = 8'h00;
        add_req(4'd2, 4'hF, 1'b1);
        drain();

        regs[7] = 8'h00;
        add_req(4'd7, 4'd2, 1'b0);
        add_req(4'd9, 4'd9, 1'b1);
        drain();

        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
        add_req(4'd10, 4'd0,  1'b1);
        add_req(4'd11, 4'd1,  1'b1);
        add_req(4'd12, 4'd3,  1'b0);
        add_req(4'd13, 4'd4,  1'b1);
        add_req(4'd14, 4'hF,  1'b1);
        drain();

        add_req(4'd5, 4'd6, 1'b1);
        add_req(4'd6, 4'd7, 1'b1);
        run_cycle();
        run_cycle();
        run_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_reset("midrst");
        mq.delete();
        stim.delete();
        last_w = -100;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) run_cycle();

        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
        regs[$urandom_range(0, 15)] = 8'h00;
        regs[$urandom_range(0, 15)] = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (stim.size() == 0 && $urandom_range(0, 9) < 6) begin
                add_req(4'($urandom),
                        ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom),
                        1'($urandom));
            end
            run_cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
